// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder: packs NeXT-link audio bytes into 32-bit stereo words,
// buffers them in a small FIFO and hands one word to the I2S sender per request
// tick. A four-state session FSM (IDLE/PRIME/RUN/DRAIN) gates byte intake and
// playback, and the block keeps sticky overflow/underrun diagnostics.
module audio_sample_feeder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        start_cmd,
  input  logic        end_cmd,
  input  logic        rate_22k_in,
  input  logic        audio_req_tick,
  input  logic        audio_req_mode_in,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        audio_start_out,
  output logic        audio_end_out,
  output logic        audio_22k_out,
  output logic        next_req,
  output logic        overflow,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   pack_q, pack_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          start_pulse_q, start_pulse_d;
  logic          end_pulse_q, end_pulse_d;
  logic          rate_q, rate_d;
  logic          next_req_q, next_req_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    ucnt_q, ucnt_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   push_word;
  logic          push, pop, flush, accept, full, empty, room;

  // Next-state logic: byte packing, FIFO bookkeeping, session FSM, diagnostics
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    pack_d        = pack_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    start_pulse_d = 1'b0;
    end_pulse_d   = 1'b0;
    rate_d        = rate_q;
    next_req_d    = 1'b0;
    overflow_d    = overflow_q;
    underrun_d    = underrun_q;
    ucnt_d        = ucnt_q;
    push          = 1'b0;
    flush         = 1'b0;
    push_word     = {pack_q, byte_in};

    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    accept = byte_valid && ((state_q == ST_PRIME) || (state_q == ST_RUN));
    pop    = audio_req_tick && !empty && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    // A complete word may enter a full FIFO only when a pop frees a slot this cycle
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      pack_d     = {pack_q[15:0], byte_in};
      if (byte_cnt_q == 2'd3) begin
        if (!full || pop) push = 1'b1;
        else              overflow_d = 1'b1;
      end
    end

    if (audio_req_tick && empty && (state_q == ST_RUN)) begin
      underrun_d = 1'b1;
      if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
    end

    // A partially packed word counts as an occupied slot when deciding to ask for more
    room = ((count_q + CW'(byte_cnt_q != 2'd0)) < DEPTH_C);
    next_req_d = audio_req_tick && room &&
                 ((state_q == ST_PRIME) || ((state_q == ST_RUN) && audio_req_mode_in));

    if (pop) begin
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_cmd) begin
          state_d    = ST_PRIME;
          flush      = 1'b1;
          overflow_d = 1'b0;
          underrun_d = 1'b0;
          ucnt_d     = 8'd0;
          rate_d     = rate_22k_in;
        end
      end
      ST_PRIME: begin
        if (end_cmd) begin
          state_d = ST_IDLE;
          flush   = 1'b1;
        end else if (count_q >= PRIME_C) begin
          state_d       = ST_RUN;
          start_pulse_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (end_cmd) state_d = ST_DRAIN;
      end
      default: begin
        if (empty) begin
          state_d     = ST_IDLE;
          end_pulse_d = 1'b1;
        end
      end
    endcase

    // Byte intake is closed in IDLE and DRAIN, so any partial word is discarded
    if ((state_d == ST_IDLE) || (state_d == ST_DRAIN)) byte_cnt_d = 2'd0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and output registers, cleared asynchronously by reset
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= 2'd0;
      pack_q        <= 24'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= 32'd0;
      out_valid_q   <= 1'b0;
      start_pulse_q <= 1'b0;
      end_pulse_q   <= 1'b0;
      rate_q        <= 1'b0;
      next_req_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      pack_q        <= pack_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      start_pulse_q <= start_pulse_d;
      end_pulse_q   <= end_pulse_d;
      rate_q        <= rate_d;
      next_req_q    <= next_req_d;
      overflow_q    <= overflow_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge in_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign audio_start_out = start_pulse_q;
  assign audio_end_out   = end_pulse_q;
  assign audio_22k_out   = rate_q;
  assign next_req        = next_req_q;
  assign overflow        = overflow_q;
  assign underrun        = underrun_q;
  assign underrun_cnt    = ucnt_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder (FIFO_DEPTH=4, PRIME_LEVEL=2).
module tb_audio_sample_feeder;

  logic        in_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        start_cmd = 1'b0;
  logic        end_cmd = 1'b0;
  logic        rate_22k_in = 1'b0;
  logic        audio_req_tick = 1'b0;
  logic        audio_req_mode_in = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, audio_start_out, audio_end_out, audio_22k_out;
  logic        next_req, overflow, underrun;
  logic [7:0]  underrun_cnt;

  int n_pass = 0;
  int n_total = 0;

  audio_sample_feeder #(.FIFO_DEPTH(4), .PRIME_LEVEL(2)) dut (
    .in_clk(in_clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .start_cmd(start_cmd), .end_cmd(end_cmd), .rate_22k_in(rate_22k_in),
    .audio_req_tick(audio_req_tick), .audio_req_mode_in(audio_req_mode_in),
    .out_data(out_data), .out_valid(out_valid), .audio_start_out(audio_start_out),
    .audio_end_out(audio_end_out), .audio_22k_out(audio_22k_out), .next_req(next_req),
    .overflow(overflow), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    string       name;
    logic [7:0]  b;
    logic        bv, st, en, rate, tick, mode;
    logic [31:0] data;
    logic        vld, s, e, r, nreq, ovf, und;
    logic [7:0]  ucnt;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [63:0] mk(logic [31:0] d, logic v, logic s, logic e, logic r,
                                     logic n, logic o, logic u, logic [7:0] c);
    return {17'd0, d, v, s, e, r, n, o, u, c};
  endfunction

  function automatic logic [63:0] outs();
    return mk(out_data, out_valid, audio_start_out, audio_end_out, audio_22k_out,
              next_req, overflow, underrun, underrun_cnt);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
    byte_valid = 1'b0; start_cmd = 1'b0; end_cmd = 1'b0;
    audio_req_tick = 1'b0; audio_req_mode_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      byte_in = 8'(w >> (24 - 8 * i));
      byte_valid = 1'b1;
      step();
    end
  endtask

  task automatic do_tick(input logic mode);
    audio_req_tick = 1'b1;
    audio_req_mode_in = mode;
    step();
  endtask

  initial begin
    //             name       b     bv st en rt tk md   data          v  s  e  r  n  o  u  ucnt
    tbl[0]  = '{"start",    8'h00, 0, 1, 0, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[1]  = '{"b11",      8'h11, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[2]  = '{"b22",      8'h22, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[3]  = '{"b33",      8'h33, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[4]  = '{"b44",      8'h44, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[5]  = '{"prime_nreq",8'h00,0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 1, 1, 0, 0, 8'd0};
    tbl[6]  = '{"b55",      8'h55, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[7]  = '{"b66",      8'h66, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[8]  = '{"b77",      8'h77, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[9]  = '{"b88",      8'h88, 1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[10] = '{"start_pls",8'h00, 0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 8'd0};
    tbl[11] = '{"run_idle", 8'h00, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[12] = '{"pop1",     8'h00, 0, 0, 0, 0, 1, 0, 32'h11223344, 1, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[13] = '{"hold1",    8'h00, 0, 0, 0, 0, 0, 0, 32'h11223344, 0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[14] = '{"pop2_nreq",8'h00, 0, 0, 0, 0, 1, 1, 32'h55667788, 1, 0, 0, 1, 1, 0, 0, 8'd0};
    tbl[15] = '{"hold2",    8'h00, 0, 0, 0, 0, 0, 0, 32'h55667788, 0, 0, 0, 1, 0, 0, 0, 8'd0};
    tbl[16] = '{"under1",   8'h00, 0, 0, 0, 0, 1, 0, 32'h55667788, 0, 0, 0, 1, 0, 0, 1, 8'd1};
    tbl[17] = '{"under2",   8'h00, 0, 0, 0, 0, 1, 0, 32'h55667788, 0, 0, 0, 1, 0, 0, 1, 8'd2};
    tbl[18] = '{"under3",   8'h00, 0, 0, 0, 0, 1, 0, 32'h55667788, 0, 0, 0, 1, 0, 0, 1, 8'd3};

    // Reset state
    #2;
    chk("reset_outs", outs(), 64'd0);
    @(posedge in_clk); @(posedge in_clk); #1;
    rst = 1'b0;

    // Session start, priming, playback and first underruns
    for (int i = 0; i < 19; i++) begin
      byte_in = tbl[i].b; byte_valid = tbl[i].bv; start_cmd = tbl[i].st; end_cmd = tbl[i].en;
      rate_22k_in = tbl[i].rate; audio_req_tick = tbl[i].tick; audio_req_mode_in = tbl[i].mode;
      step();
      chk(tbl[i].name, outs(), mk(tbl[i].data, tbl[i].vld, tbl[i].s, tbl[i].e, tbl[i].r,
                                  tbl[i].nreq, tbl[i].ovf, tbl[i].und, tbl[i].ucnt));
    end

    // Underrun counter saturation: 258 empty ticks in total
    audio_req_tick = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(posedge in_clk); #1;
    end
    audio_req_tick = 1'b0;
    chk("ucnt_sat", {56'd0, underrun_cnt}, 64'd255);
    chk("under_valid", {63'd0, out_valid}, 64'd0);
    do_tick(1'b0);
    chk("ucnt_hold", {56'd0, underrun_cnt}, 64'd255);

    // Overflow: four words fill the FIFO, a fifth is dropped
    send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4);
    send_word(32'hC1C2C3C4); send_word(32'hD1D2D3D4);
    chk("no_ovf_full", {63'd0, overflow}, 64'd0);
    send_word(32'hE1E2E3E4);
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    do_tick(1'b1);
    chk("full_nreq", {63'd0, next_req}, 64'd0);
    chk("full_pop", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hA1A2A3A4});
    do_tick(1'b0); chk("ovf_pop2", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hB1B2B3B4});
    do_tick(1'b0); chk("ovf_pop3", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hC1C2C3C4});
    do_tick(1'b0); chk("ovf_pop4", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hD1D2D3D4});
    do_tick(1'b0); chk("ovf_empty", {31'd0, out_valid, out_data}, {31'd0, 1'b0, 32'hD1D2D3D4});

    // Drain: end_cmd with two words left
    send_word(32'h0A0B0C0D); send_word(32'h1A1B1C1D);
    end_cmd = 1'b1; step();
    chk("drain_enter", {63'd0, audio_end_out}, 64'd0);
    do_tick(1'b0); chk("drain_pop1", {30'd0, audio_end_out, out_valid, out_data}, {30'd0, 2'b01, 32'h0A0B0C0D});
    do_tick(1'b0); chk("drain_pop2", {30'd0, audio_end_out, out_valid, out_data}, {30'd0, 2'b01, 32'h1A1B1C1D});
    step(); chk("end_pulse", {62'd0, audio_end_out, out_valid}, 64'd2);
    step(); chk("end_clear", {63'd0, audio_end_out}, 64'd0);
    do_tick(1'b0); chk("idle_no_pop", {63'd0, out_valid}, 64'd0);

    // New session: pop coincident with a push into a full FIFO
    start_cmd = 1'b1; rate_22k_in = 1'b0; step();
    chk("restart_clr", outs(), mk(32'h1A1B1C1D, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    send_word(32'h01020304); send_word(32'h05060708);
    send_word(32'h090A0B0C); send_word(32'h0D0E0F10);
    for (int i = 0; i < 3; i++) begin
      byte_in = 8'(32'h11121314 >> (24 - 8 * i)); byte_valid = 1'b1; step();
    end
    byte_in = 8'h14; byte_valid = 1'b1; audio_req_tick = 1'b1; step();
    chk("full_pushpop", {30'd0, overflow, out_valid, out_data}, {30'd0, 2'b01, 32'h01020304});
    do_tick(1'b0); chk("pp_pop2", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h05060708});
    do_tick(1'b0); chk("pp_pop3", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h090A0B0C});
    do_tick(1'b0); chk("pp_pop4", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h0D0E0F10});
    do_tick(1'b0); chk("pp_pop5", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h11121314});
    do_tick(1'b0);
    chk("pp_empty", {22'd0, overflow, underrun, underrun_cnt, out_valid, out_data},
        {22'd0, 1'b0, 1'b1, 8'd1, 1'b0, 32'h11121314});

    // Asynchronous reset in mid-session
    send_word(32'hCAFEF00D);
    do_tick(1'b0);
    chk("pre_rst", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'hCAFEF00D});
    #2 rst = 1'b1;
    #1 chk("async_rst", outs(), 64'd0);
    @(posedge in_clk); #1;
    chk("rst_hold", outs(), 64'd0);
    rst = 1'b0;
    start_cmd = 1'b1; rate_22k_in = 1'b1; step();
    chk("post_rst_start", outs(), mk(32'h0, 0, 0, 0, 1, 0, 0, 0, 8'd0));

    // End in PRIME aborts with a flush and no pulses
    send_word(32'hDEADBEEF);
    end_cmd = 1'b1; step();
    chk("prime_abort", {62'd0, audio_start_out, audio_end_out}, 64'd0);
    step();
    chk("prime_abort2", {62'd0, audio_start_out, audio_end_out}, 64'd0);
    start_cmd = 1'b1; rate_22k_in = 1'b1; step();
    send_word(32'h76543210); step();
    chk("flushed_no_start", {63'd0, audio_start_out}, 64'd0);
    send_word(32'h89ABCDEF); step();
    chk("reprime_start", {63'd0, audio_start_out}, 64'd1);
    do_tick(1'b0);
    chk("flushed_pop", {31'd0, out_valid, out_data}, {31'd0, 1'b1, 32'h76543210});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 The block SHALL have the parameter FIFO_DEPTH, default 4, meaning the number of 32-bit sample words buffered (power of two, 2..16).
REQ-002 The block SHALL have the parameter PRIME_LEVEL, default 2, meaning the number of buffered words required before playback starts (1..FIFO_DEPTH).
REQ-003 The block SHALL have the port in_clk, input, 1 bit, the sole clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit, reset; it SHALL be asynchronous and active-high.
REQ-005 The block SHALL have the port byte_in, input, 8 bits, the audio byte from the NeXT link.
REQ-006 The block SHALL have the port byte_valid, input, 1 bit, qualifying byte_in for one cycle.
REQ-007 The block SHALL have the port start_cmd, input, 1 bit, a pulse that begins a playback session.
REQ-008 The block SHALL have the port end_cmd, input, 1 bit, a pulse that ends the session after the buffered data drains.
REQ-009 The block SHALL have the port rate_22k_in, input, 1 bit, the sample rate sampled on start_cmd (1 = 22 kHz, 0 = 44 kHz).
REQ-010 The block SHALL have the port audio_req_tick, input, 1 bit, the per-frame sample request pulse from the I2S sender.
REQ-011 The block SHALL have the port audio_req_mode_in, input, 1 bit, the I2S sender request-mode flag.
REQ-012 The block SHALL have the port out_data, output, 32 bits, the sample word to the I2S sender: L in [31:16], R in [15:0].
REQ-013 The block SHALL have the port out_valid, output, 1 bit, a one-cycle pulse qualifying out_data.
REQ-014 The block SHALL have the ports audio_start_out and audio_end_out, outputs, 1 bit each, one-cycle session pulses to the I2S sender.
REQ-015 The block SHALL have the port audio_22k_out, output, 1 bit, the rate latched for the session.
REQ-016 The block SHALL have the port next_req, output, 1 bit, a one-cycle pulse asking the NeXT side for one more sample word.
REQ-017 The block SHALL have the ports overflow and underrun, outputs, 1 bit each, sticky error flags cleared on start_cmd.
REQ-018 The block SHALL have the port underrun_cnt, output, 8 bits, a saturating count of underruns.

Function
REQ-019 The byte packer SHALL place bytes MSB-first: the 1st byte in [31:24] through the 4th byte in [7:0]; a 2-bit byte counter SHALL wrap 3->0 on the 4th byte.
REQ-020 On the 4th byte, the packer SHALL push the word if the FIFO is not full; if the FIFO is full, it SHALL drop the word and set overflow.
REQ-021 Bytes SHALL be accepted only in PRIME and RUN; in IDLE and DRAIN, byte_valid SHALL be ignored and the byte counter held at 0.
REQ-022 The FSM SHALL have the states IDLE, PRIME, RUN and DRAIN.
REQ-023 In IDLE, start_cmd SHALL cause: ->PRIME; flush the FIFO; clear the byte counter, overflow, underrun and underrun_cnt; latch audio_22k_out <= rate_22k_in.
REQ-024 In PRIME, FIFO count reaching PRIME_LEVEL SHALL cause ->RUN and audio_start_out pulsed high the following cycle.
REQ-025 In PRIME, end_cmd SHALL cause ->IDLE with a FIFO flush and no start or end pulse.
REQ-026 In RUN, end_cmd SHALL cause ->DRAIN; in DRAIN, FIFO count==0 SHALL cause ->IDLE and audio_end_out pulsed high the following cycle.
REQ-027 When start_cmd and end_cmd are coincident, start_cmd SHALL take priority in IDLE, and end_cmd SHALL take priority in PRIME, RUN and DRAIN; start_cmd SHALL be ignored outside IDLE.
REQ-028 Pops SHALL occur only in RUN and DRAIN, on audio_req_tick with the FIFO non-empty.
REQ-029 out_data SHALL be the popped word registered, and out_valid SHALL be high exactly 1 cycle after the tick; out_data SHALL hold until the next pop.
REQ-030 audio_req_tick with the FIFO empty in RUN SHALL cause no out_valid, underrun set, and underrun_cnt +1, saturating at 255.
REQ-031 An empty-FIFO tick in DRAIN SHALL not count as an underrun.
REQ-032 A push and a pop in the same cycle SHALL both take effect with the count unchanged; a pop and push while full SHALL be legal (no overflow).
REQ-033 next_req SHALL pulse 1 cycle after audio_req_tick when all of the following hold: state is PRIME, or state is RUN with audio_req_mode_in=1; and count + (byte counter != 0) < FIFO_DEPTH.
REQ-034 At most one next_req SHALL be issued per tick.
REQ-035 The FIFO pointers SHALL be log2(FIFO_DEPTH) bits wrapping modulo depth; the count SHALL be log2(FIFO_DEPTH)+1 bits.

Reset
REQ-036 While rst=1, the block SHALL force: state IDLE, FIFO empty, byte counter 0, every output 0 (out_data=32'h0).
REQ-037 Reset asserted mid-session SHALL abort immediately, with no audio_end_out pulse.
REQ-038 After rst deasserts, the first start_cmd SHALL be honoured on the next rising edge.

Verification
REQ-039 The bench SHALL cover: start_cmd (rate_22k_in=1), then bytes 11 22 33 44 and 55 66 77 88 -> audio_start_out 1 cycle after the 8th byte, audio_22k_out=1.
REQ-040 The bench SHALL cover: RUN with 2 words, 2 ticks -> out_valid pulses with 32'h11223344 then 32'h55667788, each 1 cycle after its tick.
REQ-041 The bench SHALL cover: RUN with the FIFO empty and 3 ticks -> no out_valid, underrun=1, underrun_cnt=3; with 258 ticks -> underrun_cnt=255.
REQ-042 The bench SHALL cover: DEPTH=4 full plus 4 more bytes -> overflow=1, count stays 4, next_req not pulsed on a tick with audio_req_mode_in=1.
REQ-043 The bench SHALL cover: a tick popping on the same cycle the 4th byte arrives while full -> count stays 4, overflow=0.
REQ-044 The bench SHALL cover: end_cmd in RUN with 2 words left, 2 ticks -> 2 out_valid pulses, then audio_end_out 1 cycle after empty, state IDLE; rst asserted mid-RUN -> all outputs 0 asynchronously.
